clkmon: RTL and testbench

- Frequency monitor for the generated system clock.
- Samples an asynchronous clock under test (e.g. the divided oscillator output) in the monitor clock domain and counts its rising edges over a programmable window of monitor-clock cycles.
- Compares the count against low/high limits; result and flags are readable by test logic.
- Used for oscillator bring-up and as a divider sanity check, typically on the JTAG clock.

---
 rtl/clkmon_if.sv | 33 +++
 rtl/clkmon.sv | 140 ++++++++++++++
 tb/tb_clkmon.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/clkmon_if.sv
//==============================================================================
// clkmon_if : control/result bundle between test logic and the clkmon monitor.
// Rev 1.0
//==============================================================================
`default_nettype none

interface clkmon_if #(
  parameter int CNT_W = 16,
  parameter int WIN_W = 16
);
  logic             i_start;
  logic [WIN_W-1:0] i_win;
  logic [CNT_W-1:0] i_lo;
  logic [CNT_W-1:0] i_hi;
  logic             o_busy;
  logic             o_done;
  logic [CNT_W-1:0] o_cnt;
  logic             o_too_slow;
  logic             o_too_fast;
  logic             o_ovf;

  modport master (
    output i_start, i_win, i_lo, i_hi,
    input  o_busy, o_done, o_cnt, o_too_slow, o_too_fast, o_ovf
  );

  modport slave (
    input  i_start, i_win, i_lo, i_hi,
    output o_busy, o_done, o_cnt, o_too_slow, o_too_fast, o_ovf
  );
endinterface

`default_nettype wire

// File: rtl/clkmon.sv
//==============================================================================
// clkmon : counts rising edges of an async clock over a window of clk cycles
//          and flags too-slow/too-fast results. CLKMON_CONT_EN = continuous mode.
// Rev 1.0
//==============================================================================
`default_nettype none

module clkmon #(
  parameter int CNT_W       = 16,
  parameter int WIN_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_clk_meas,
  clkmon_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_MEAS = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_rise;
  logic                   w_accept;
  logic [WIN_W-1:0]       r_win_cnt;
  logic [CNT_W-1:0]       r_edge;
  logic                   r_ovf_acc;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_slow;
  logic                   r_fast;
  logic                   r_ovf;
  logic                   r_done;
`ifdef CLKMON_CONT_EN
  logic [WIN_W-1:0]       r_win_len;
`endif

  assign w_rise   = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign w_accept = bus.i_start && (bus.i_win != '0);

  // prev always tracks sync_out, so the ARM cycle absorbs any pre-start level
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_clk_meas};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_ARM;
      S_ARM:  w_next = S_MEAS;
      S_MEAS: if (r_win_cnt == WIN_W'(1)) w_next = S_DONE;
`ifdef CLKMON_CONT_EN
      S_DONE: w_next = bus.i_start ? S_ARM : S_IDLE;
`else
      S_DONE: w_next = S_IDLE;
`endif
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_win_cnt <= '0;
      r_edge    <= '0;
      r_ovf_acc <= 1'b0;
      r_cnt     <= '0;
      r_slow    <= 1'b0;
      r_fast    <= 1'b0;
      r_ovf     <= 1'b0;
      r_done    <= 1'b0;
`ifdef CLKMON_CONT_EN
      r_win_len <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_win_cnt <= bus.i_win;
            r_edge    <= '0;
            r_ovf_acc <= 1'b0;
`ifdef CLKMON_CONT_EN
            r_win_len <= bus.i_win;
`endif
          end
        end
        S_MEAS: begin
          r_win_cnt <= r_win_cnt - WIN_W'(1);
          if (w_rise) begin
            if (&r_edge) r_ovf_acc <= 1'b1;
            else         r_edge    <= r_edge + CNT_W'(1);
          end
        end
        S_DONE: begin
          r_cnt  <= r_edge;
          r_slow <= (r_edge < bus.i_lo);
          r_fast <= (r_edge > bus.i_hi);
          r_ovf  <= r_ovf_acc;
          r_done <= 1'b1;
`ifdef CLKMON_CONT_EN
          if (bus.i_start) begin
            r_win_cnt <= r_win_len;
            r_edge    <= '0;
            r_ovf_acc <= 1'b0;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.o_busy     = (r_state == S_ARM) || (r_state == S_MEAS);
  assign bus.o_done     = r_done;
  assign bus.o_cnt      = r_cnt;
  assign bus.o_too_slow = r_slow;
  assign bus.o_too_fast = r_fast;
  assign bus.o_ovf      = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_clkmon.sv
//==============================================================================
// tb_clkmon : directed scoreboard bench for clkmon (16-bit and 4-bit counters).
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_clkmon;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic m2 = 1'b0;
  logic m4 = 1'b0;
  always @(negedge clk) begin
    m2 <= ~m2;
    m4 <= m4 ^ m2;
  end

  logic [1:0] mode_a = 2'd0;
  logic [1:0] mode_b = 2'd0;
  logic       meas_a;
  logic       meas_b;
  assign meas_a = (mode_a == 2'd1) ? m4 : (mode_a == 2'd2) ? m2 : 1'b0;
  assign meas_b = (mode_b == 2'd1) ? m4 : (mode_b == 2'd2) ? m2 : 1'b0;

  clkmon_if #(.CNT_W(16), .WIN_W(16)) ifa ();
  clkmon_if #(.CNT_W(4),  .WIN_W(16)) ifb ();

  clkmon #(.CNT_W(16), .WIN_W(16), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .rst(rst), .i_clk_meas(meas_a), .bus(ifa.slave));
  clkmon #(.CNT_W(4), .WIN_W(16), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .rst(rst), .i_clk_meas(meas_b), .bus(ifb.slave));

  typedef struct {
    logic [15:0] cnt;
    logic        slow;
    logic        fast;
    logic        ovf;
  } exp_t;
  exp_t sb[$];

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit sel, input bit start, input int win, input int lo, input int hi);
    if (sel) begin
      ifb.i_start = start; ifb.i_win = 16'(win); ifb.i_lo = 4'(lo); ifb.i_hi = 4'(hi);
    end else begin
      ifa.i_start = start; ifa.i_win = 16'(win); ifa.i_lo = 16'(lo); ifa.i_hi = 16'(hi);
    end
  endtask

  task automatic sample(input bit sel, output logic b, output logic d, output logic [15:0] c,
                        output logic s, output logic f, output logic o);
    if (sel) begin
      b = ifb.o_busy; d = ifb.o_done; c = 16'(ifb.o_cnt);
      s = ifb.o_too_slow; f = ifb.o_too_fast; o = ifb.o_ovf;
    end else begin
      b = ifa.o_busy; d = ifa.o_done; c = ifa.o_cnt;
      s = ifa.o_too_slow; f = ifa.o_too_fast; o = ifa.o_ovf;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // one single-shot measurement; optional ignored start pulses during MEAS
  task automatic run(input bit sel, input int win, input int lo, input int hi,
                     input logic [15:0] ecnt, input bit es, input bit ef, input bit eo,
                     input bit pulses);
    exp_t e;
    int   done_idx = -1;
    int   busy_n   = 0;
    int   ndone    = 0;
    logic b, d, s, f, o;
    logic [15:0] c;
    e.cnt = ecnt; e.slow = es; e.fast = ef; e.ovf = eo;
    sb.push_back(e);
    set_in(sel, 1'b1, win, lo, hi);
    cycle();
    set_in(sel, 1'b0, win, lo, hi);
    for (int i = 0; i < win + 8; i++) begin
      sample(sel, b, d, c, s, f, o);
      if (b) busy_n++;
      if (d) begin
        ndone++;
        done_idx = i;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("cnt", 32'(c), 32'(e.cnt));
          check("too_slow", 32'(s), 32'(e.slow));
          check("too_fast", 32'(f), 32'(e.fast));
          check("ovf", 32'(o), 32'(e.ovf));
        end
      end
      if (pulses) set_in(sel, (i == 10) || (i == 50), win, lo, hi);
      cycle();
    end
    check("done_count", 32'(ndone), 32'd1);
    check("latency", 32'(done_idx), 32'(win + 2));
    check("busy_cycles", 32'(busy_n), 32'(win + 1));
  endtask

  initial begin
    logic b, d, s, f, o;
    logic [15:0] c;
    int   nb, nd;

    set_in(1'b0, 1'b0, 0, 0, 0);
    set_in(1'b1, 1'b0, 0, 0, 0);
    rst = 1'b1;
    repeat (3) cycle();
    sample(1'b0, b, d, c, s, f, o);
    check("reset_a", {26'd0, b, d, s, f, o, |c}, 32'd0);
    sample(1'b1, b, d, c, s, f, o);
    check("reset_b", {26'd0, b, d, s, f, o, |c}, 32'd0);
    rst = 1'b0;
    cycle();

    // nominal clk/4 input, then both limit violations
    mode_a = 2'd1;
    run(1'b0, 100, 20, 30, 16'd25, 1'b0, 1'b0, 1'b0, 1'b0);
    run(1'b0, 100, 30, 40, 16'd25, 1'b1, 1'b0, 1'b0, 1'b0);
    run(1'b0, 100, 10, 20, 16'd25, 1'b0, 1'b1, 1'b0, 1'b0);

    // 4-bit counter saturation, then a quiet input clears ovf
    mode_b = 2'd2;
    run(1'b1, 100, 0, 15, 16'd15, 1'b0, 1'b0, 1'b1, 1'b0);
    mode_b = 2'd0;
    run(1'b1, 100, 0, 15, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // zero window is ignored and results hold
    set_in(1'b0, 1'b1, 0, 20, 30);
    cycle();
    set_in(1'b0, 1'b0, 0, 20, 30);
    nb = 0; nd = 0;
    for (int i = 0; i < 10; i++) begin
      sample(1'b0, b, d, c, s, f, o);
      if (b) nb++;
      if (d) nd++;
      cycle();
    end
    check("win0_busy", 32'(nb), 32'd0);
    check("win0_done", 32'(nd), 32'd0);
    check("win0_cnt_hold", 32'(c), 32'd25);
    check("win0_fast_hold", 32'(f), 32'd1);

    run(1'b0, 100, 20, 30, 16'd25, 1'b0, 1'b0, 1'b0, 1'b1);

    // reset in the middle of a window
    set_in(1'b0, 1'b1, 100, 20, 30);
    cycle();
    set_in(1'b0, 1'b0, 100, 20, 30);
    for (int i = 0; i < 50; i++) cycle();
    sample(1'b0, b, d, c, s, f, o);
    check("pre_rst_busy", 32'(b), 32'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    sample(1'b0, b, d, c, s, f, o);
    check("rst_busy", 32'(b), 32'd0);
    check("rst_cnt", 32'(c), 32'd0);
    check("rst_done", 32'(d), 32'd0);
    nb = 0; nd = 0;
    for (int i = 0; i < 110; i++) begin
      sample(1'b0, b, d, c, s, f, o);
      if (b) nb++;
      if (d) nd++;
      cycle();
    end
    check("post_rst_busy", 32'(nb), 32'd0);
    check("post_rst_done", 32'(nd), 32'd0);
    run(1'b0, 100, 20, 30, 16'd25, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef CLKMON_CONT_EN
    begin
      exp_t e;
      int   last = -1;
      e.cnt = 16'd10; e.slow = 1'b0; e.fast = 1'b0; e.ovf = 1'b0;
      for (int k = 0; k < 4; k++) sb.push_back(e);
      set_in(1'b0, 1'b1, 40, 5, 15);
      cycle();
      nd = 0;
      for (int i = 0; i < 200; i++) begin
        sample(1'b0, b, d, c, s, f, o);
        if (d) begin
          nd++;
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check("cont_cnt", 32'(c), 32'(e.cnt));
            check("cont_flags", {29'd0, s, f, o}, {29'd0, e.slow, e.fast, e.ovf});
          end
          if (last >= 0) check("cont_period", 32'(i - last), 32'd42);
          else           check("cont_first", 32'(i), 32'd42);
          last = i;
          if (nd == 3) set_in(1'b0, 1'b0, 40, 5, 15);
        end
        cycle();
      end
      sample(1'b0, b, d, c, s, f, o);
      check("cont_done_count", 32'(nd), 32'd4);
      check("cont_idle_busy", 32'(b), 32'd0);
    end
`endif

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
